// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, sample type and saturating add for the echo path
package audio_pkg;
  localparam int WL_DEFAULT = 32;
  typedef logic signed [WL_DEFAULT-1:0] sample_t;
  // Clamp a WL+1-bit sum back into the WL-bit signed range
  function automatic sample_t sat_add(input logic signed [WL_DEFAULT:0] s);
    return (s[WL_DEFAULT] != s[WL_DEFAULT-1]) ? {s[WL_DEFAULT], {(WL_DEFAULT-1){~s[WL_DEFAULT]}}} : s[WL_DEFAULT-1:0];
  endfunction
endpackage

// File: rtl/audio_dpram.sv
// audio_dpram: simple dual-port RAM, one write port, one registered read port
module audio_dpram #(
  parameter int WL = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [WL-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [WL-1:0] rd
);
  logic [WL-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/audio_echo.sv
// audio_echo: single-tap echo mixer over a circular delay line.
// Define AUDIO_ECHO_SAT_EN to saturate the mix; otherwise the sum wraps.
module audio_echo
  import audio_pkg::*;
#(
  parameter int WL  = WL_DEFAULT,
  parameter int AW  = 10,
  parameter int ATT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] adc_data,
  input  logic          rx_done,
  input  logic          tx_done,
  input  logic          echo_en,
  input  logic [AW-1:0] delay_len,
  output logic [WL-1:0] dac_data,
  output logic          mix_valid,
  output logic          underrun
);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  logic [AW-1:0] wp_q, wp_d, ra;
  logic [AW:0]   fill_q, fill_d;
  logic          v1_q, v1_d, tap_q, tap_d, mv_q, mv_d, pend_q, pend_d, und_q, und_d;
  logic [WL-1:0] dry_q, dry_d, dac_q, dac_d, rd_data;
  logic signed [WL:0] wet_x, sum;
  audio_dpram #(.WL(WL), .AW(AW)) u_ram (
    .clk(clk),
    .we (rx_done),
    .wa (wp_q),
    .wd (adc_data),
    .ra (ra),
    .rd (rd_data)
  );
  always_comb begin
    wp_d   = wp_q + AW'(rx_done);
    fill_d = (rx_done && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    ra     = wp_q - delay_len;
    v1_d   = rx_done;
    // Fill gating keeps stale RAM after reset (and the delay_len=0 write/read collision) off the output
    tap_d  = rx_done & echo_en & (|delay_len) & (fill_q >= {1'b0, delay_len});
    dry_d  = adc_data;
    wet_x  = tap_q ? $signed({rd_data[WL-1], rd_data}) : '0;
    sum    = $signed({dry_q[WL-1], dry_q}) + (wet_x >>> ATT);
`ifdef AUDIO_ECHO_SAT_EN
    dac_d  = v1_q ? sat_add(sum) : dac_q;
`else
    dac_d  = v1_q ? sum[WL-1:0] : dac_q;
`endif
    mv_d   = v1_q;
    pend_d = (pend_q | mv_q) & ~tx_done;
    und_d  = und_q | (tx_done & ~pend_q & ~mv_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q   <= '0;
      fill_q <= '0;
      v1_q   <= 1'b0;
      tap_q  <= 1'b0;
      dry_q  <= '0;
      dac_q  <= '0;
      mv_q   <= 1'b0;
      pend_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
      v1_q   <= v1_d;
      tap_q  <= tap_d;
      dry_q  <= dry_d;
      dac_q  <= dac_d;
      mv_q   <= mv_d;
      pend_q <= pend_d;
      und_q  <= und_d;
    end
  end
  assign dac_data  = dac_q;
  assign mix_valid = mv_q;
  assign underrun  = und_q;
endmodule

// File: tb/tb_audio_echo.sv
// tb_audio_echo: three configurations (AW10/ATT1, AW3/ATT1, AW10/ATT0) against a history-queue model
module tb_audio_echo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adc = '0;
  logic        rx = 1'b0, tx = 1'b0, echo_en = 1'b0;
  logic [9:0]  dl = '0;
  logic [31:0] dac_o [3];
  logic        mv_o [3];
  logic        und_o [3];
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  audio_echo #(.WL(32), .AW(10), .ATT(1)) u0 (.clk(clk), .rst(rst), .adc_data(adc), .rx_done(rx),
    .tx_done(tx), .echo_en(echo_en), .delay_len(dl), .dac_data(dac_o[0]), .mix_valid(mv_o[0]), .underrun(und_o[0]));
  audio_echo #(.WL(32), .AW(3), .ATT(1)) u1 (.clk(clk), .rst(rst), .adc_data(adc), .rx_done(rx),
    .tx_done(tx), .echo_en(echo_en), .delay_len(dl[2:0]), .dac_data(dac_o[1]), .mix_valid(mv_o[1]), .underrun(und_o[1]));
  audio_echo #(.WL(32), .AW(10), .ATT(0)) u2 (.clk(clk), .rst(rst), .adc_data(adc), .rx_done(rx),
    .tx_done(tx), .echo_en(echo_en), .delay_len(dl), .dac_data(dac_o[2]), .mix_valid(mv_o[2]), .underrun(und_o[2]));

  // Reference model: every sample since reset, plus expected output state per instance
  logic [31:0] hist [$];
  logic        s1v_m [3] = '{0, 0, 0};
  logic [31:0] s1d_m [3] = '{0, 0, 0};
  logic        mv_m  [3] = '{0, 0, 0};
  logic [31:0] dac_m [3] = '{0, 0, 0};
  logic        pend_m[3] = '{0, 0, 0};
  logic        und_m [3] = '{0, 0, 0};
  logic [31:0] outs0 [$], outs1 [$], outs2 [$];

  function automatic logic [31:0] mix(input int k, input logic [31:0] x);
    longint s, wet;
    int n, d;
    n = hist.size();
    d = (k == 1) ? int'(dl[2:0]) : int'(dl);
    wet = (d != 0 && echo_en && n >= d) ? longint'($signed(hist[n-d])) : 64'sd0;
    s = longint'($signed(x)) + (wet >>> ((k == 2) ? 0 : 1));
`ifdef AUDIO_ECHO_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 3; k++) begin
        s1v_m[k] = 0; mv_m[k] = 0; dac_m[k] = 0; pend_m[k] = 0; und_m[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (tx) begin
          if (!pend_m[k] && !mv_m[k]) und_m[k] = 1;
          pend_m[k] = 0;
        end else if (mv_m[k]) pend_m[k] = 1;
        mv_m[k] = s1v_m[k];
        if (s1v_m[k]) dac_m[k] = s1d_m[k];
        s1v_m[k] = rx;
        if (rx) s1d_m[k] = mix(k, adc);
      end
      if (rx) hist.push_back(adc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d mix_valid", k), {31'd0, mv_o[k]}, {31'd0, mv_m[k]});
      chk($sformatf("u%0d dac_data", k), dac_o[k], dac_m[k]);
      chk($sformatf("u%0d underrun", k), {31'd0, und_o[k]}, {31'd0, und_m[k]});
    end
    if (mv_o[0]) outs0.push_back(dac_o[0]);
    if (mv_o[1]) outs1.push_back(dac_o[1]);
    if (mv_o[2]) outs2.push_back(dac_o[2]);
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic sample(input logic [31:0] x); adc = x; rx = 1; tick(); rx = 0; endtask
  task automatic do_rst(); rst = 1; tick(); rst = 0; tick(); endtask
  task automatic clr(); outs0.delete(); outs1.delete(); outs2.delete(); endtask

  initial begin
    logic [31:0] v [4];
    logic [31:0] r;
    tick(); tick();
    @(negedge clk);
    chk("reset dac", dac_o[0], 32'h0);
    chk("reset mv", {31'd0, mv_o[0]}, 32'h0);
    chk("reset und", {31'd0, und_o[0]}, 32'h0);
    rst = 0;
    tick(); tick();
    // dry pass-through, exact two-cycle latency
    echo_en = 0; dl = 4;
    sample(32'h0000_1234);
    @(negedge clk);
    chk("dry mv early", {31'd0, mv_o[0]}, 32'h0);
    tick();
    @(negedge clk);
    chk("dry mv", {31'd0, mv_o[0]}, 32'h1);
    chk("dry dac", dac_o[0], 32'h0000_1234);
    tick();
    // echo with fill gating
    do_rst(); clr(); echo_en = 1; dl = 4;
    sample(100); sample(0); sample(0); sample(0); sample(0);
    repeat (4) tick();
    chk("echo count", outs0.size(), 5);
    chk("echo first", outs0[0], 100);
    chk("echo gated", outs0[3], 0);
    chk("echo fifth", outs0[4], 50);
    chk("echo fifth att0", outs2[4], 100);
    // wrap on the 8-word line
    do_rst(); clr(); dl = 2;
    for (int k = 0; k < 20; k++) sample(k * 10);
    repeat (4) tick();
    chk("wrap 9", outs1[9], 125);
    chk("wrap 19", outs1[19], 275);
    // saturation / wrap of the sum
    do_rst(); clr(); dl = 1;
    sample(32'h7FFF_FFF0); sample(32'h0000_0100);
    repeat (4) tick();
`ifdef AUDIO_ECHO_SAT_EN
    chk("sat att0", outs2[1], 32'h7FFF_FFFF);
`else
    chk("sat att0", outs2[1], 32'h8000_00F0);
`endif
    chk("sat att1", outs0[1], 32'h4000_00F8);
    // underrun: coincident tx consumes, a second tx underruns
    do_rst(); clr();
    sample(5); tick();
    tx = 1; tick(); tx = 0; tick();
    @(negedge clk);
    chk("und coincide", {31'd0, und_o[0]}, 32'h0);
    tick();
    tx = 1; tick(); tx = 0; tick();
    @(negedge clk);
    chk("und set", {31'd0, und_o[0]}, 32'h1);
    chk("und dac hold", dac_o[0], 32'h5);
    tick();
    // reset mid-stream, then dry until refilled
    do_rst(); dl = 4;
    for (int k = 0; k < 6; k++) sample($urandom);
    do_rst(); clr();
    for (int k = 0; k < 4; k++) begin v[k] = $urandom; sample(v[k]); end
    repeat (4) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("post rst dry %0d", k), outs0[k], v[k]);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_rst();
      if ($urandom_range(0, 39) == 0) dl = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 12));
      if ($urandom_range(0, 59) == 0) echo_en = ~echo_en;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: adc = {8'h7F, r[23:0]};
        1: adc = {8'h80, r[23:0]};
        default: adc = r;
      endcase
      rx = $urandom_range(0, 1);
      tx = ($urandom_range(0, 3) == 0);
      tick();
    end
    rx = 0; tx = 0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/audio_echo.md
# audio_echo

Single-tap echo stage between the WM8978 receive path and transmit path. Each received sample (adc_data qualified by rx_done) is written into a circular delay line. The block mixes the sample with an attenuated copy of the sample received delay_len words earlier, and the mixed result drives the dac_data input of the transmit path. It runs in the audio bit-clock domain, so rx_done and tx_done are single-cycle strobes in clk.

## Interface
- WL, 32: sample word length in bits; samples are signed two's complement.
- AW, 10: delay-line address width; depth is 2^AW words.
- ATT, 1: wet-path attenuation as an arithmetic right shift; 0 gives unity gain.

- clk  in  1  audio bit clock, the same clock that produces rx_done and tx_done.
- rst  in  1  asynchronous active-high reset.
- adc_data  in  WL  received sample.
- rx_done  in  1  one-cycle strobe; adc_data is valid in this cycle.
- tx_done  in  1  one-cycle strobe; the transmit path has consumed the current dac_data.
- echo_en  in  1  1 = mix the wet tap; 0 = dry pass-through, while the delay line keeps being written.
- delay_len  in  AW  tap distance in words; 0 disables the wet path.
- dac_data  out  WL  mixed sample to the transmit path.
- mix_valid  out  1  one-cycle strobe; dac_data was updated in this cycle.
- underrun  out  1  sticky flag; set when tx_done arrives with no new sample since the previous tx_done.

## Operation
- Left and right words interleave on rx_done, and delay_len counts words. Even delay_len keeps the two channels aligned; odd values cross the channels, which is legal and not checked.
- Write pointer wp, AW bits:
  - On rx_done, adc_data is written to mem[wp] and wp increments.
  - wp wraps from 2^AW-1 to 0.
- Read address: (wp - delay_len) mod 2^AW, sampled in the rx_done cycle using the pre-increment wp.
- Fill counter fill, AW+1 bits:
  - Increments on each rx_done.
  - Saturates at 2^AW.
- Tap validity:
  - The tap is valid when delay_len != 0, echo_en = 1 and fill >= delay_len, all sampled in the rx_done cycle.
  - When the tap is invalid, the wet term is 0. This prevents stale RAM contents after reset.
- Mix: dac_data = dry + (wet >>> ATT), computed in WL+1 bits and then reduced to WL bits as set under Configuration.
- Pipeline: S0 (write and read issue) → S1 (RAM data out) → S2 (sum registered into dac_data, mix_valid = 1).
  - Fully pipelined: rx_done may assert on consecutive cycles.
  - delay_len and echo_en are captured per sample in S0.
- Underrun tracking: a pending flag sets on mix_valid and clears on tx_done.
  - If tx_done arrives while pending = 0, underrun sets.
  - If mix_valid and tx_done coincide, it counts as consumption of the new sample: no underrun, and pending = 0.
  - If rx_done and the read address coincide (delay_len = 0), the wet term is forced to 0, so RAM read-during-write behaviour does not matter.
- Reset mid-stream:
  - wp, fill, pipeline valids, dac_data, mix_valid, pending and underrun all clear at once.
  - RAM contents are not cleared; the fill gating makes this invisible at the output.

## Timing
- Reset values: dac_data = 0, mix_valid = 0, underrun = 0.
- Latency: rx_done in cycle n gives mix_valid and the new dac_data in cycle n+2.
- dac_data holds between mix_valid strobes. The transmit path may sample it at any time.
- Throughput: one sample per cycle. The real rate is one word per WL bclk cycles.
- underrun rises in the cycle after the offending tx_done and stays high until rst.

## Configuration
- AUDIO_ECHO_SAT_EN defined: the WL+1-bit sum saturates to the range [-2^(WL-1), 2^(WL-1)-1].
- AUDIO_ECHO_SAT_EN undefined: the sum truncates to its low WL bits, wrapping in two's complement. This saves the clamp comparators.

## Structure
- Package audio_pkg holds:
  - the WL default constant;
  - the sample_t typedef (signed [WL-1:0]);
  - the sat_add function used when AUDIO_ECHO_SAT_EN is defined.
- One sub-module, audio_dpram:
  - simple dual-port synchronous RAM, one write port and one read port;
  - 1-cycle registered read;
  - depth 2^AW, width WL.
- audio_echo holds the pointers, fill counter, pipeline, mix and underrun logic.

## Test plan
- Dry path, echo_en = 0: rx_done with adc_data = 0x0000_1234 → dac_data = 0x0000_1234 and mix_valid exactly 2 cycles later.
- Echo, delay_len = 4, ATT = 1: write 100, 0, 0, 0, 0 → fifth output = 0 + 50; the first four outputs have no wet term, because fill gating holds the tap invalid until fill >= 4.
- Wrap, AW = 3, delay_len = 2: stream 20 samples through → sample k output = x[k] + x[k-2]/2 across the pointer wrap.
- Saturation, ATT = 0, delay_len = 1: inputs 0x7FFF_FFF0 then 0x0000_0100 → 0x7FFF_FFFF with AUDIO_ECHO_SAT_EN defined; 0x8000_00F0 (wrapped) without it.
- Underrun: two tx_done with no rx_done between them → underrun = 1 and dac_data unchanged; a mix_valid coinciding with tx_done → underrun stays 0.
- Reset mid-stream: assert rst after 6 samples with delay_len = 4 → outputs clear; the next 4 samples come out dry.
